// File: rtl/msk_unmask_pkg.sv
// Shared constants for the serial share-recombination stage: FSM encoding
// and the counter-width helper.
package msk_unmask_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // max(1, clog2(n)); a single-bit counter still exists for n <= 2
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msk_share_shift_reg.sv
// Share holding register: parallel load with one-share pre-shift, zero-fill
// shift toward share 0, and scrub. Only the bottom share is visible outside.
module msk_share_shift_reg #(
  parameter int d = 2,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           shift,
  input  logic           clear,
  input  logic [d*W-1:0] din,
  output logic [W-1:0]   bottom
);

  logic [d*W-1:0] share_reg;

  // Share 0 goes straight to the accumulator on load, so it is dropped here
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      share_reg <= '0;
    end else if (load) begin
      share_reg <= din >> W;
    end else if (shift) begin
      share_reg <= share_reg >> W;
    end else begin
      share_reg <= share_reg;
    end
  end

  assign bottom = share_reg[W-1:0];

endmodule

// File: rtl/msk_unmask_serial.sv
// Serial unmasking stage: registers a d-share sharing, XOR-folds one share per
// clock into acc, presents the cleartext on a valid/ready port, then scrubs.
module msk_unmask_serial
  import msk_unmask_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [d*W-1:0] in_shares,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           busy
);

  localparam int CW = cnt_width(d);
  localparam logic [CW-1:0] CNT_LAST = CW'(d - 1);

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  bottom;
  logic          accept;
  logic          release_out;

  assign accept      = (state == ST_IDLE) && in_valid;
  assign release_out = (state == ST_DONE) && out_ready;

  msk_share_shift_reg #(
    .d(d),
    .W(W)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (state == ST_ACC),
    .clear (release_out),
    .din   (in_shares),
    .bottom(bottom)
  );

  // FSM, accumulator and share counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc   <= in_shares[W-1:0];
            cnt   <= CW'(1);
            state <= (d > 1) ? ST_ACC : ST_DONE;
          end
        end
        ST_ACC: begin
          acc <= acc ^ bottom;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          acc   <= '0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs depend on registered state only; partial sums never leak out
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = out_valid ? acc : '0;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_msk_unmask_serial.sv
// Self-checking bench: directed scenarios on d=1,2,3 instances and a random
// back-to-back stream on a d=4, W=16 instance against a queue-based model.
module tb_msk_unmask_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iv_1, ir_1, ov_1, or_1, b_1;
  logic [7:0]  is_1, od_1;
  logic        iv_2, ir_2, ov_2, or_2, b_2;
  logic [15:0] is_2;
  logic [7:0]  od_2;
  logic        iv_3, ir_3, ov_3, or_3, b_3;
  logic [23:0] is_3;
  logic [7:0]  od_3;
  logic        iv_4, ir_4, ov_4, or_4, b_4;
  logic [63:0] is_4;
  logic [15:0] od_4;

  msk_unmask_serial #(.d(1), .W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_1), .in_ready(ir_1), .in_shares(is_1),
    .out_valid(ov_1), .out_ready(or_1), .out_data(od_1), .busy(b_1));
  msk_unmask_serial #(.d(2), .W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_2), .in_ready(ir_2), .in_shares(is_2),
    .out_valid(ov_2), .out_ready(or_2), .out_data(od_2), .busy(b_2));
  msk_unmask_serial #(.d(3), .W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_3), .in_ready(ir_3), .in_shares(is_3),
    .out_valid(ov_3), .out_ready(or_3), .out_data(od_3), .busy(b_3));
  msk_unmask_serial #(.d(4), .W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_4), .in_ready(ir_4), .in_shares(is_4),
    .out_valid(ov_4), .out_ready(or_4), .out_data(od_4), .busy(b_4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++;
    if ({ir_1, ov_1, od_1, b_1} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_d1 got %b required 1_0_00000000_0", {ir_1, ov_1, od_1, b_1});
    end
    checks++;
    if ({ir_2, ov_2, od_2, b_2} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_d2 got %b required 1_0_00000000_0", {ir_2, ov_2, od_2, b_2});
    end
    checks++;
    if ({ir_3, ov_3, od_3, b_3} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_d3 got %b required 1_0_00000000_0", {ir_3, ov_3, od_3, b_3});
    end
    checks++;
    if ({ir_4, ov_4, od_4, b_4} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL reset_d4 got %b required 1_0_0_0", {ir_4, ov_4, od_4, b_4});
    end
  endtask

  task automatic test_d2_basic();
    is_2 = {8'h3C, 8'hA5}; iv_2 = 1'b1; or_2 = 1'b1;
    checks++;
    if (ir_2 !== 1'b1) begin errors++; $display("FAIL d2_ready_c0 got %b required 1", ir_2); end
    step();
    iv_2 = 1'b0; is_2 = 16'($urandom);
    checks++;
    if ({ov_2, od_2, b_2} !== {1'b0, 8'h00, 1'b1}) begin
      errors++; $display("FAIL d2_c1 got %b required 0_00000000_1", {ov_2, od_2, b_2});
    end
    step();
    checks++;
    if ({ov_2, od_2} !== {1'b1, 8'h99}) begin
      errors++; $display("FAIL d2_out_c2 got valid=%b data=%h required 1/99", ov_2, od_2);
    end
    step();
    checks++;
    if ({ir_2, ov_2, b_2} !== {1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL d2_c3 got ready/valid/busy=%b required 100", {ir_2, ov_2, b_2});
    end
  endtask

  task automatic test_d3_basic();
    is_3 = {8'hFF, 8'hF0, 8'h0F}; iv_3 = 1'b1; or_3 = 1'b1;
    step();
    iv_3 = 1'b0;
    for (int k = 1; k < 3; k++) begin
      checks++;
      if ({ov_3, od_3} !== {1'b0, 8'h00}) begin
        errors++; $display("FAIL d3_pre_c%0d got valid=%b data=%h required 0/00", k, ov_3, od_3);
      end
      step();
    end
    checks++;
    if ({ov_3, od_3} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL d3_out got valid=%b data=%h required 1/00", ov_3, od_3);
    end
    step();
  endtask

  task automatic test_d1_basic();
    is_1 = 8'h5A; iv_1 = 1'b1; or_1 = 1'b1;
    step();
    iv_1 = 1'b0;
    checks++;
    if ({ov_1, od_1} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL d1_out got valid=%b data=%h required 1/5a", ov_1, od_1);
    end
    checks++;
    if (u1.state === 2'd1) begin errors++; $display("FAIL d1_no_acc got state=%0d required not 1", u1.state); end
    step();
    checks++;
    if (ir_1 !== 1'b1) begin errors++; $display("FAIL d1_ready got %b required 1", ir_1); end
  endtask

  task automatic test_backpressure();
    is_2 = {8'h3C, 8'hA5}; iv_2 = 1'b1; or_2 = 1'b0;
    step();
    is_2 = {8'h12, 8'h34};
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({ov_2, od_2, ir_2, b_2} !== {1'b1, 8'h99, 1'b0, 1'b1}) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b d=%h r=%b b=%b required 1/99/0/1", k, ov_2, od_2, ir_2, b_2);
      end
      step();
    end
    or_2 = 1'b1;
    checks++;
    if ({ov_2, od_2, ir_2} !== {1'b1, 8'h99, 1'b0}) begin
      errors++; $display("FAIL bp_release got v=%b d=%h r=%b required 1/99/0", ov_2, od_2, ir_2);
    end
    step();
    checks++;
    if (ir_2 !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b required 1", ir_2); end
    step();
    iv_2 = 1'b0;
    step();
    checks++;
    if ({ov_2, od_2} !== {1'b1, 8'h26}) begin
      errors++; $display("FAIL bp_second got valid=%b data=%h required 1/26", ov_2, od_2);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    is_3 = 24'($urandom) | 24'h000001; iv_3 = 1'b1; or_3 = 1'b1;
    step();
    iv_3 = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({ir_3, ov_3, od_3, b_3} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL rst_mid_outputs got %b required 1_0_00000000_0", {ir_3, ov_3, od_3, b_3});
    end
    checks++;
    if ((u3.acc !== 8'h00) || (u3.u_shift.share_reg !== 24'h0)) begin
      errors++; $display("FAIL rst_mid_scrub got acc=%h share_reg=%h required 0/0", u3.acc, u3.u_shift.share_reg);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ov_3 === 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_output got %b required 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int acc_q[$];
    int cyc = 0, accepted = 0, popped = 0, last_acc = -100;
    logic prev_ov = 1'b0;
    logic [15:0] x;
    while (popped < 1000 && cyc < 30000) begin
      iv_4 = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      is_4 = {$urandom, $urandom};
      or_4 = ($urandom_range(0, 2) != 0);
      if (iv_4 && ir_4) begin
        x = 16'h0000;
        for (int s = 0; s < 4; s++) x = x ^ is_4[s*16 +: 16];
        exp_q.push_back(x);
        acc_q.push_back(cyc);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc < 5) begin
            errors++; $display("FAIL b2b_throughput got gap=%0d required >=5", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepted++;
      end
      if (ov_4) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious got data=%h required no output", od_4);
        end else begin
          if (od_4 !== exp_q[0]) begin
            errors++; $display("FAIL b2b_data got %h required %h", od_4, exp_q[0]);
          end
          if (!prev_ov) begin
            checks++;
            if (cyc != acc_q[0] + 4) begin
              errors++; $display("FAIL b2b_latency got %0d required %0d", cyc - acc_q[0], 4);
            end
          end
          if (or_4) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            popped++;
          end
        end
      end else begin
        checks++;
        if (od_4 !== 16'h0000) begin errors++; $display("FAIL b2b_idle_data got %h required 0000", od_4); end
      end
      prev_ov = ov_4 && !or_4;
      step();
      cyc++;
    end
    iv_4 = 1'b0;
    checks++;
    if (popped != 1000) begin errors++; $display("FAIL b2b_budget got %0d words required 1000", popped); end
  endtask

  initial begin
    rst_n = 1'b0;
    iv_1 = 1'b0; or_1 = 1'b0; is_1 = '0;
    iv_2 = 1'b0; or_2 = 1'b0; is_2 = '0;
    iv_3 = 1'b0; or_3 = 1'b0; is_3 = '0;
    iv_4 = 1'b0; or_4 = 1'b0; is_4 = '0;
    #1;
    test_reset();
    test_d2_basic();
    test_d3_basic();
    test_d1_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_unmask_serial.md
# msk_unmask_serial

Serial unmasking (share-recombination) stage at the output end of a masked pipeline built from MSK gadgets. It accepts one d-share Boolean sharing of a W-bit word over a valid/ready handshake and registers all shares. It then XOR-folds the shares into the cleartext one share per clock, so no combinational path ever mixes more than two shares. The cleartext is presented on a valid/ready output, and all internal share state is scrubbed afterwards.

## Interface
Parameters:
- d, default 2: number of shares, ≥1.
- W, default 8: bits per share.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: sharing on in_shares is valid.
- in_ready, output, 1: block can accept a sharing.
- in_shares, input, d*W: share i occupies bits [i*W +: W].
- out_valid, output, 1: out_data holds the cleartext.
- out_ready, input, 1: consumer accepts out_data.
- out_data, output, W: unmasked word.
- busy, output, 1: state ≠ IDLE.

## Operation
- States: IDLE, ACC, DONE.
- Registers:
  - share_reg, d*W bits: shift register.
  - acc, W bits.
  - cnt, CW = max(1, clog2(d)) bits.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready:
    - share_reg <= in_shares shifted down by W, with zero fill.
    - acc <= in_shares[0 +: W].
    - cnt <= 1.
    - Next state is ACC if d > 1, else DONE.
- ACC:
  - acc <= acc ^ share_reg[0 +: W].
  - share_reg shifts down by W, zero fill.
  - cnt increments.
  - When cnt == d-1 (this edge consumes the last share), next state is DONE.
  - in_ready = 0.
- DONE:
  - out_valid = 1 and out_data = acc.
  - On out_ready: acc <= 0, share_reg <= 0, cnt <= 0, next state IDLE.
  - in_ready = 0. A new input is not accepted in the same cycle as the output handshake.
- out_data is forced to 0 whenever out_valid = 0, so partial XOR sums never appear on the output.
- in_valid is ignored outside IDLE. in_shares is sampled only on the accept edge and need not be held afterwards.
- Arithmetic is pure bitwise XOR; there are no carries or width growth.
- Reset, whether applied mid-ACC or mid-DONE, takes effect on the next edge:
  - state goes to IDLE.
  - share_reg, acc and cnt go to 0.
  - The in-flight word is discarded. No out_valid pulse occurs for it.
- Values after reset:
  - in_ready = 1.
  - out_valid = 0.
  - out_data = 0.
  - busy = 0.

## Timing
- Latency: input handshake in cycle t gives out_valid = 1 in cycle t+d (d=1: t+1; d=2: t+2).
- out_valid stays high and out_data stays stable until out_ready is seen. This holds for any length of backpressure.
- Output handshake in cycle u gives in_ready = 1 in cycle u+1.
- Maximum throughput is one word per d+1 cycles with out_ready held at 1.
- in_ready, out_valid, out_data and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Share handling:
  - Exactly one share enters the XOR each cycle, from the bottom of share_reg.
  - No share is XORed combinationally with in_shares.

## Structure
- Shared package msk_unmask_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_ACC=2'd1, ST_DONE=2'd2.
  - Function for CW = max(1, clog2(d)).
- One sub-module, msk_share_shift_reg, parameterised by d and W. Its controls are:
  - load: parallel load with one-share pre-shift.
  - shift: zero-fill shift down by W.
  - clear.
  - It outputs the bottom share.
- FSM, acc and cnt live in the top module.

## Test plan
- d=2, W=8, shares {0x3C, 0xA5} (share1, share0), out_ready=1. Required response:
  - Accept in cycle 0.
  - out_valid=1 with out_data=0x99 in cycle 2.
  - in_ready=1 in cycle 3.
- d=3, W=8, shares {0xFF, 0xF0, 0x0F}: out_data=0x00 with out_valid=1 at t+3. Before that cycle, out_data=0.
- d=1, W=8, share 0x5A: out_valid in cycle t+1 with out_data=0x5A. ACC is never entered.
- Backpressure, d=2 with shares {0x3C, 0xA5}:
  - Hold out_ready=0 for 5 cycles while in_valid=1 with a new sharing.
  - Required: out_data holds 0x99, in_ready=0 and busy=1 throughout.
  - The second word is accepted only in the cycle after out_ready=1.
- Reset mid-operation: d=3, drop rst_n in cycle t+1 after accept. Required:
  - Next cycle: IDLE, in_ready=1, out_valid=0, out_data=0.
  - Internal share_reg and acc read 0.
  - No later out_valid occurs for the dropped word.
- Back-to-back random stream (d=4, W=16, 1000 words, random in_valid and out_ready):
  - out_data equals the XOR of the 4 shares of each accepted word, in order.
  - Throughput is never better than one word per 5 cycles.
